dispense_scheduler: RTL

DISPENSE_SCHEDULER -- requirements
Module: dispense_scheduler

---
 rtl/dispense_pkg.sv | 78 +++++++
 rtl/dispense_scheduler_rr_arbiter.sv | 53 +++++
 rtl/dispense_scheduler.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/dispense_pkg.sv
// ---------------------------------------------------------------------------
// dispense_pkg
// Shared definitions for the fluid dispense scheduler: fluid codes, status
// codes, FSM state encoding, slab pricing rates and loyalty discount tiers,
// plus the pricing helper functions used by the CHECK stage.
// ---------------------------------------------------------------------------
package dispense_pkg;

    typedef enum logic [1:0] {
        FLUID_WATER = 2'b00,
        FLUID_JUICE = 2'b01,
        FLUID_CHEM  = 2'b10,
        FLUID_BAD   = 2'b11
    } fluid_e;

    typedef enum logic [1:0] {
        ST_OK        = 2'b00,
        ST_NO_STOCK  = 2'b01,
        ST_BAD_FLUID = 2'b10,
        ST_ZERO_VOL  = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CHECK    = 2'd1,
        S_DISPENSE = 2'd2,
        S_DONE     = 2'd3
    } state_e;

    // Slab rates: first litre, then every further litre.
    localparam logic [15:0] RATE_WATER_FIRST = 16'd20;
    localparam logic [15:0] RATE_WATER_REST  = 16'd10;
    localparam logic [15:0] RATE_JUICE_FIRST = 16'd50;
    localparam logic [15:0] RATE_JUICE_REST  = 16'd30;
    localparam logic [15:0] RATE_CHEM_FIRST  = 16'd40;
    localparam logic [15:0] RATE_CHEM_REST   = 16'd20;

    // Loyalty tiers, keyed on successful transactions before this one.
    localparam logic [3:0] DISC_TIER1_MIN = 4'd3;
    localparam logic [3:0] DISC_TIER2_MIN = 4'd5;
    localparam logic [7:0] DISC_TIER1_PCT = 8'd10;
    localparam logic [7:0] DISC_TIER2_PCT = 8'd20;

    // Undiscounted price. Only meaningful for vol >= 1; a zero volume is
    // rejected before the price is ever used.
    function automatic logic [15:0] slab_price(input logic [1:0] fluid,
                                               input logic [7:0] vol);
        logic [15:0] first;
        logic [15:0] rest;
        logic [15:0] extra;
        first = RATE_WATER_FIRST;
        rest  = RATE_WATER_REST;
        case (fluid)
            FLUID_JUICE: begin first = RATE_JUICE_FIRST; rest = RATE_JUICE_REST; end
            FLUID_CHEM:  begin first = RATE_CHEM_FIRST;  rest = RATE_CHEM_REST;  end
            default:     begin first = RATE_WATER_FIRST; rest = RATE_WATER_REST; end
        endcase
        extra = {8'd0, vol} - 16'd1;
        return first + extra * rest;
    endfunction

    function automatic logic [7:0] discount_pct(input logic [3:0] count);
        if (count < DISC_TIER1_MIN)      return 8'd0;
        else if (count < DISC_TIER2_MIN) return DISC_TIER1_PCT;
        else                             return DISC_TIER2_PCT;
    endfunction

    // final = price - floor(price * pct / 100); the product needs 24 bits.
    function automatic logic [15:0] apply_discount(input logic [15:0] price,
                                                   input logic [3:0]  count);
        logic [23:0] prod;
        logic [23:0] cut;
        prod = {8'd0, price} * {16'd0, discount_pct(count)};
        cut  = prod / 24'd100;
        return price - cut[15:0];
    endfunction

endpackage

// File: rtl/dispense_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin selector for the kiosk request ports. The search starts at the
// pointer; the pointer moves to (granted + 1) mod NUM_REQ only when the
// grant is actually accepted. NUM_REQ must be at least 2.
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset (pointer -> 0)
//   i_req        request vector
//   i_accept     grant is being consumed this cycle
//   o_grant      one-hot grant (all zero when no request)
//   o_grant_idx  binary index of the granted port
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int PW      = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_accept,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PW-1:0]      o_grant_idx
);

    logic [PW-1:0] r_ptr;

    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        o_grant     = '0;
        o_grant_idx = '0;
        found       = 1'b0;
        idx         = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PW'((int'(r_ptr) + i) % NUM_REQ);
            if (!found && i_req[idx]) begin
                found       = 1'b1;
                o_grant[idx] = 1'b1;
                o_grant_idx = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_accept) begin
            r_ptr <= (o_grant_idx == PW'(NUM_REQ - 1)) ? '0 : o_grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/dispense_scheduler.sv
// ---------------------------------------------------------------------------
// dispense_scheduler
// Serialises kiosk dispense requests onto a single pump. One request is
// granted in IDLE, validated and priced in CHECK, pumped for
// volume*TICKS_PER_L cycles in DISPENSE and reported in DONE.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   req_valid/req_ready     per-port request / one-cycle accept pulse
//   req_fluid/volume/user   packed per-port fields (2/8/4 bits per port)
//   pump_on, pump_sel       pump enable and fluid select
//   done_valid              one-cycle completion pulse
//   done_port/status        port index and result code of that completion
//   done_price/remaining    charged price, post-transaction stock of fluid
//   busy                    high whenever the FSM is not IDLE
//   o_dbg_state             current FSM state
//   refill_valid/fluid/amt  stock top-up (only with STOCK_REFILL_EN defined)
//
// Build option: define STOCK_REFILL_EN to add the refill ports; without it
// stock only ever decreases.
//
// On a rejected request with fluid code 11 there is no stock to report, so
// done_remaining reads 0.
// ---------------------------------------------------------------------------
module dispense_scheduler
    import dispense_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int TICKS_PER_L = 4,
    parameter  int WATER_INIT  = 100,
    parameter  int JUICE_INIT  = 80,
    parameter  int CHEM_INIT   = 60,
    localparam int PW          = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [2*NUM_REQ-1:0] req_fluid,
    input  logic [8*NUM_REQ-1:0] req_volume,
    input  logic [4*NUM_REQ-1:0] req_user,
`ifdef STOCK_REFILL_EN
    input  logic                 refill_valid,
    input  logic [1:0]           refill_fluid,
    input  logic [7:0]           refill_amt,
`endif
    output logic                 pump_on,
    output logic [1:0]           pump_sel,
    output logic                 done_valid,
    output logic [PW-1:0]        done_port,
    output logic [1:0]           done_status,
    output logic [15:0]          done_price,
    output logic [15:0]          done_remaining,
    output logic                 busy,
    output state_e               o_dbg_state
);

    state_e        r_state;
    state_e        w_next_state;

    logic [PW-1:0] r_port;
    logic [1:0]    r_fluid;
    logic [7:0]    r_volume;
    logic [3:0]    r_user;
    logic [1:0]    r_status;
    logic [15:0]   r_price;
    logic [15:0]   r_remaining;
    logic [23:0]   r_pump_cnt;
    logic [3:0]    r_count [16];
    logic [15:0]   r_stock_water;
    logic [15:0]   r_stock_juice;
    logic [15:0]   r_stock_chem;

    logic [NUM_REQ-1:0] w_grant;
    logic [PW-1:0]      w_grant_idx;
    logic               w_accept;
    logic [15:0]        w_stock_cur;
    logic [1:0]         w_status;
    logic               w_ok;
    logic [15:0]        w_price_final;
    logic [7:0]         w_debit_water, w_debit_juice, w_debit_chem;
    logic [7:0]         w_add_water,   w_add_juice,   w_add_chem;
    logic [15:0]        w_water_nxt,   w_juice_nxt,   w_chem_nxt;
    logic [15:0]        w_remaining;

    // Requests are only looked at while IDLE; everything else ignores valid.
    assign w_accept = (r_state == S_IDLE) && (|req_valid);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk         (clk),
        .reset       (reset),
        .i_req       (req_valid),
        .i_accept    (w_accept),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    // ---------------- CHECK stage evaluation ----------------
    always_comb begin
        case (r_fluid)
            FLUID_WATER: w_stock_cur = r_stock_water;
            FLUID_JUICE: w_stock_cur = r_stock_juice;
            FLUID_CHEM:  w_stock_cur = r_stock_chem;
            default:     w_stock_cur = 16'd0;
        endcase
        if (r_fluid == FLUID_BAD)                w_status = ST_BAD_FLUID;
        else if (r_volume == 8'd0)               w_status = ST_ZERO_VOL;
        else if ({8'd0, r_volume} > w_stock_cur) w_status = ST_NO_STOCK;
        else                                     w_status = ST_OK;
    end

    assign w_ok          = (r_state == S_CHECK) && (w_status == ST_OK);
    assign w_price_final = apply_discount(slab_price(r_fluid, r_volume), r_count[r_user]);

    assign w_debit_water = (w_ok && r_fluid == FLUID_WATER) ? r_volume : 8'd0;
    assign w_debit_juice = (w_ok && r_fluid == FLUID_JUICE) ? r_volume : 8'd0;
    assign w_debit_chem  = (w_ok && r_fluid == FLUID_CHEM)  ? r_volume : 8'd0;

`ifdef STOCK_REFILL_EN
    assign w_add_water = (refill_valid && refill_fluid == FLUID_WATER) ? refill_amt : 8'd0;
    assign w_add_juice = (refill_valid && refill_fluid == FLUID_JUICE) ? refill_amt : 8'd0;
    assign w_add_chem  = (refill_valid && refill_fluid == FLUID_CHEM)  ? refill_amt : 8'd0;
`else
    assign w_add_water = 8'd0;
    assign w_add_juice = 8'd0;
    assign w_add_chem  = 8'd0;
`endif

    // Debit never exceeds stock (checked above), so only the top needs
    // saturation; debit and refill land together in one cycle.
    function automatic logic [15:0] stock_next(input logic [15:0] s,
                                               input logic [7:0]  debit,
                                               input logic [7:0]  add);
        logic [16:0] sum;
        sum = {1'b0, s} - {9'd0, debit} + {9'd0, add};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    assign w_water_nxt = stock_next(r_stock_water, w_debit_water, w_add_water);
    assign w_juice_nxt = stock_next(r_stock_juice, w_debit_juice, w_add_juice);
    assign w_chem_nxt  = stock_next(r_stock_chem,  w_debit_chem,  w_add_chem);

    always_comb begin
        case (r_fluid)
            FLUID_WATER: w_remaining = w_water_nxt;
            FLUID_JUICE: w_remaining = w_juice_nxt;
            FLUID_CHEM:  w_remaining = w_chem_nxt;
            default:     w_remaining = 16'd0;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Outputs decode straight from state so reset silences them at once.
    always_comb begin
        w_next_state   = r_state;
        req_ready      = '0;
        pump_on        = 1'b0;
        pump_sel       = 2'b00;
        done_valid     = 1'b0;
        done_port      = '0;
        done_status    = 2'b00;
        done_price     = 16'd0;
        done_remaining = 16'd0;
        busy           = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_accept) begin
                    req_ready    = w_grant;
                    w_next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                w_next_state = (w_status == ST_OK) ? S_DISPENSE : S_DONE;
            end
            S_DISPENSE: begin
                pump_on  = 1'b1;
                pump_sel = r_fluid;
                if (r_pump_cnt == 24'd1) w_next_state = S_DONE;
            end
            S_DONE: begin
                done_valid     = 1'b1;
                done_port      = r_port;
                done_status    = r_status;
                done_price     = r_price;
                done_remaining = r_remaining;
                w_next_state   = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign o_dbg_state = r_state;

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_port        <= '0;
            r_fluid       <= 2'b00;
            r_volume      <= 8'd0;
            r_user        <= 4'd0;
            r_status      <= 2'b00;
            r_price       <= 16'd0;
            r_remaining   <= 16'd0;
            r_pump_cnt    <= 24'd0;
            r_stock_water <= 16'(WATER_INIT);
            r_stock_juice <= 16'(JUICE_INIT);
            r_stock_chem  <= 16'(CHEM_INIT);
            for (int i = 0; i < 16; i++) r_count[i] <= 4'd0;
        end else begin
            if (w_accept) begin
                r_port   <= w_grant_idx;
                r_fluid  <= req_fluid[{w_grant_idx, 1'b0} +: 2];
                r_volume <= req_volume[{w_grant_idx, 3'b000} +: 8];
                r_user   <= req_user[{w_grant_idx, 2'b00} +: 4];
            end
            if (r_state == S_CHECK) begin
                r_status    <= w_status;
                r_price     <= w_ok ? w_price_final : 16'd0;
                r_remaining <= w_remaining;
                r_pump_cnt  <= w_ok ? ({16'd0, r_volume} * 24'(TICKS_PER_L)) : 24'd0;
            end else if (r_state == S_DISPENSE) begin
                r_pump_cnt <= r_pump_cnt - 24'd1;
            end
            if (w_ok && r_count[r_user] != 4'hF) begin
                r_count[r_user] <= r_count[r_user] + 4'd1;
            end
            r_stock_water <= w_water_nxt;
            r_stock_juice <= w_juice_nxt;
            r_stock_chem  <= w_chem_nxt;
        end
    end

endmodule
